fan_speed_ramp_ctrl: RTL and testbench

//  Speed-level controller that drives the duty/pwm_freq inputs of the 512-step fan PWM generator.

---
 rtl/fan_ctrl_pkg.sv | 16 +
 rtl/fan_tick_gen.sv | 28 ++
 rtl/fan_speed_ramp_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fan_speed_ramp_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared widths and FSM state encoding for the fan speed ramp controller.
package fan_ctrl_pkg;

  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned DUTY_W  = 9;
  localparam int unsigned FREQ_W  = 14;
  localparam int unsigned TIMER_W = 12;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } fan_state_e;

endpackage

// File: rtl/fan_tick_gen.sv
// Free-running modulo-DIV counter; tick is high for one clock when the count is DIV-1.
module fan_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fan_speed_ramp_ctrl.sv
// Button-driven fan level controller with soft-start/stop duty slewing toward the level target.
// Optional auto-off timer enabled by defining FAN_TIMER_EN.
module fan_speed_ramp_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned PWM_FREQ     = 10_000,
  parameter int unsigned RAMP_DIV     = 100_000,
  parameter int unsigned DUTY_L1      = 170,
  parameter int unsigned DUTY_L2      = 340,
  parameter int unsigned DUTY_L3      = 511,
  parameter int unsigned TIMER_STEP_S = 60
) (
  input  logic               clk,
  input  logic               reset_p,
  input  logic               btn_speed,
  input  logic               btn_off,
  input  logic               btn_timer,
  output logic [DUTY_W-1:0]  duty,
  output logic [FREQ_W-1:0]  pwm_freq,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               fan_on,
  output logic [TIMER_W-1:0] timer_remain
);

  function automatic logic [DUTY_W-1:0] level_target(input logic [LEVEL_W-1:0] lvl);
    unique case (lvl)
      2'd1:    return DUTY_W'(DUTY_L1);
      2'd2:    return DUTY_W'(DUTY_L2);
      2'd3:    return DUTY_W'(DUTY_L3);
      default: return '0;
    endcase
  endfunction

  logic               ramp_tick;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic [DUTY_W-1:0]  target, target_nx;
  fan_state_e         state_q, state_d;
  logic               busy_q, fan_on_q;

  fan_tick_gen #(
    .DIV (RAMP_DIV)
  ) u_ramp_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .tick    (ramp_tick)
  );

`ifdef FAN_TIMER_EN
  logic               sec_tick;
  logic [1:0]         sel_q, sel_d;
  logic [TIMER_W-1:0] remain_q, remain_d;

  fan_tick_gen #(
    .DIV (SYS_CLK_FREQ)
  ) u_sec_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .tick    (sec_tick)
  );
`else
  localparam int unsigned unused_timer_cfg = SYS_CLK_FREQ + TIMER_STEP_S;
  logic unused_btn_timer;
  assign unused_btn_timer = btn_timer;
`endif

  assign target = level_target(level_q);

  always_comb begin
    level_d = level_q;
    if (btn_off) begin
      level_d = '0;
    end else if (btn_speed) begin
      level_d = level_q + 2'd1;
    end

`ifdef FAN_TIMER_EN
    sel_d    = sel_q;
    remain_d = remain_q;
    if (btn_off || (btn_speed && level_q == 2'd3)) begin
      sel_d    = '0;
      remain_d = '0;
    end else if (btn_timer && level_q != '0) begin
      sel_d    = sel_q + 2'd1;
      remain_d = TIMER_W'(int'(sel_d) * TIMER_STEP_S);
    end else if (sec_tick && remain_q != '0 && level_q != '0) begin
      remain_d = remain_q - 1'b1;
      // Expiry forces the level off; the normal ramp-down does the rest.
      if (remain_q == TIMER_W'(1)) begin
        level_d = '0;
        sel_d   = '0;
      end
    end
`endif

    duty_d = duty_q;
    if (ramp_tick) begin
      if (duty_q < target) begin
        duty_d = duty_q + 1'b1;
      end else if (duty_q > target) begin
        duty_d = duty_q - 1'b1;
      end
    end

    // State is evaluated against next duty/target so busy matches duty in the same cycle.
    target_nx = level_target(level_d);
    state_d   = state_q;
    unique case (state_q)
      OFF: begin
        if (target_nx != '0) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (duty_d == target_nx) state_d = (target_nx == '0) ? OFF : HOLD;
        else if (duty_d > target_nx) state_d = RAMP_DOWN;
      end
      HOLD: begin
        if (duty_d < target_nx) state_d = RAMP_UP;
        else if (duty_d > target_nx) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (duty_d == target_nx) state_d = (target_nx == '0) ? OFF : HOLD;
        else if (duty_d < target_nx) state_d = RAMP_UP;
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      level_q  <= '0;
      duty_q   <= '0;
      state_q  <= OFF;
      busy_q   <= 1'b0;
      fan_on_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      duty_q   <= duty_d;
      state_q  <= state_d;
      busy_q   <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
      fan_on_q <= (duty_d != '0);
    end
  end

`ifdef FAN_TIMER_EN
  always_ff @(posedge clk) begin
    if (reset_p) begin
      sel_q    <= '0;
      remain_q <= '0;
    end else begin
      sel_q    <= sel_d;
      remain_q <= remain_d;
    end
  end
  assign timer_remain = remain_q;
`else
  assign timer_remain = '0;
`endif

  assign duty     = duty_q;
  assign level    = level_q;
  assign busy     = busy_q;
  assign fan_on   = fan_on_q;
  assign pwm_freq = FREQ_W'(PWM_FREQ);

endmodule

// File: tb/tb_fan_speed_ramp_ctrl.sv
// Bench for fan_speed_ramp_ctrl: directed scenarios plus random button traffic against a
// behavioural model. Timer checks adapt to FAN_TIMER_EN.
module tb_fan_speed_ramp_ctrl;

  localparam int RD   = 4;
  localparam int SF   = 16;
  localparam int STEP = 2;

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic        btn_speed = 1'b0;
  logic        btn_off = 1'b0;
  logic        btn_timer = 1'b0;
  logic [8:0]  duty;
  logic [13:0] pwm_freq;
  logic [1:0]  level;
  logic        busy;
  logic        fan_on;
  logic [11:0] timer_remain;

  always #5 clk = ~clk;

  fan_speed_ramp_ctrl #(
    .SYS_CLK_FREQ (SF),
    .PWM_FREQ     (10_000),
    .RAMP_DIV     (RD),
    .DUTY_L1      (170),
    .DUTY_L2      (340),
    .DUTY_L3      (511),
    .TIMER_STEP_S (STEP)
  ) dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .btn_speed    (btn_speed),
    .btn_off      (btn_off),
    .btn_timer    (btn_timer),
    .duty         (duty),
    .pwm_freq     (pwm_freq),
    .level        (level),
    .busy         (busy),
    .fan_on       (fan_on),
    .timer_remain (timer_remain)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: prescaler phase is cycles elapsed since reset.
  int m_level, m_duty, m_remain, m_sel, m_cyc;

  function automatic int tgt(input int l);
    case (l)
      1:       return 170;
      2:       return 340;
      3:       return 511;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit bs, input bit bo, input bit bt, input bit rst);
    bit ramp, sec;
    int nl, nd, t;
    if (rst) begin
      m_level = 0; m_duty = 0; m_remain = 0; m_sel = 0; m_cyc = 0;
      return;
    end
    ramp = (m_cyc % RD) == RD - 1;
    sec  = (m_cyc % SF) == SF - 1;
    m_cyc++;
    t  = tgt(m_level);
    nd = m_duty;
    if (ramp) begin
      if (nd < t) nd++;
      else if (nd > t) nd--;
    end
    nl = m_level;
    if (bo) nl = 0;
    else if (bs) nl = (m_level + 1) % 4;
`ifdef FAN_TIMER_EN
    if (bo || (bs && m_level == 3)) begin
      m_remain = 0; m_sel = 0;
    end else if (bt && m_level != 0) begin
      m_sel    = (m_sel + 1) % 4;
      m_remain = m_sel * STEP;
    end else if (sec && m_remain > 0 && m_level != 0) begin
      m_remain--;
      if (m_remain == 0) begin
        nl = 0; m_sel = 0;
      end
    end
`else
    if (bt || sec) m_remain = 0;
`endif
    m_level = nl;
    m_duty  = nd;
  endtask

  task automatic cycle(input bit bs, input bit bo, input bit bt, input bit rst);
    logic [24:0] exp;
    bit bsy;
    btn_speed = bs; btn_off = bo; btn_timer = bt; reset_p = rst;
    model_step(bs, bo, bt, rst);
    @(posedge clk);
    #1;
    btn_speed = 1'b0; btn_off = 1'b0; btn_timer = 1'b0; reset_p = 1'b0;
    bsy = (m_duty != tgt(m_level));
    exp = {9'(m_duty), 2'(m_level), bsy, (m_duty != 0), 12'(m_remain)};
    check("outputs", 64'({duty, level, busy, fan_on, timer_remain}), 64'(exp));
  endtask

  task automatic wait_duty(input int val, input int max, input string tag);
    for (int i = 0; i < max && duty != 9'(val); i++) cycle(0, 0, 0, 0);
    check(tag, 64'(duty), 64'(val));
  endtask

  initial begin
    int d0;
    // 1: reset
    cycle(0, 0, 0, 1);
    check("rst_duty", 64'(duty), 0);
    check("rst_level", 64'(level), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_fan_on", 64'(fan_on), 0);
    check("rst_pwm_freq", 64'(pwm_freq), 10000);
    check("rst_timer", 64'(timer_remain), 0);

    // 2: level 1 ramp to 170 and hold
    cycle(1, 0, 0, 0);
    check("t2_level", 64'(level), 1);
    check("t2_busy", 64'(busy), 1);
    wait_duty(170, 800, "t2_reach_170");
    check("t2_hold_busy", 64'(busy), 0);
    repeat (12) cycle(0, 0, 0, 0);
    check("t2_hold_duty", 64'(duty), 170);

    // 3: level 3 ramp to full and saturate
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("t3_level", 64'(level), 3);
    wait_duty(511, 1500, "t3_reach_511");
    repeat (20) cycle(0, 0, 0, 0);
    check("t3_stay_511", 64'(duty), 511);
    check("t3_busy", 64'(busy), 0);

    // 4: off from full, then off during a ramp-up at duty 100
    cycle(0, 1, 0, 0);
    check("t4_off_level", 64'(level), 0);
    wait_duty(0, 2200, "t4_down_to_0");
    check("t4_fan_off", 64'(fan_on), 0);
    cycle(1, 0, 0, 0);
    wait_duty(100, 500, "t4_reach_100");
    cycle(0, 1, 0, 0);
    check("t4_level0", 64'(level), 0);
    d0 = int'(duty);
    for (int i = 0; i < 8 && int'(duty) == d0; i++) cycle(0, 0, 0, 0);
    check("t4_step_down", 64'(duty), 64'(d0 - 1));
    wait_duty(0, 600, "t4_ramp_to_0");
    check("t4_fan_on_at_0", 64'(fan_on), 0);
    check("t4_busy_at_0", 64'(busy), 0);

    // 5: off beats speed; speed wraps at level 3
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("t5_level2", 64'(level), 2);
    cycle(1, 1, 0, 0);
    check("t5_off_wins", 64'(level), 0);
    repeat (3) cycle(1, 0, 0, 0);
    check("t5_level3", 64'(level), 3);
    cycle(1, 0, 0, 0);
    check("t5_wrap", 64'(level), 0);
    repeat (10) cycle(0, 0, 0, 0);

    // 6: auto-off timer
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
`ifdef FAN_TIMER_EN
    check("t6_load", 64'(timer_remain), 2);
    for (int i = 0; i < 40 && level != 2'd0; i++) cycle(0, 0, 0, 0);
    check("t6_expire_level", 64'(level), 0);
    check("t6_expire_timer", 64'(timer_remain), 0);
    wait_duty(0, 800, "t6_ramp_to_0");
`else
    check("t6_timer_off", 64'(timer_remain), 0);
    repeat (40) cycle(0, 0, 0, 0);
    check("t6_timer_stays_0", 64'(timer_remain), 0);
    check("t6_level_kept", 64'(level), 1);
`endif

    // Random button traffic with occasional mid-operation reset
    for (int i = 0; i < 5000; i++) begin
      cycle(($urandom % 40) == 0, ($urandom % 150) == 0, ($urandom % 50) == 0,
            ($urandom % 700) == 0);
    end
    check("end_pwm_freq", 64'(pwm_freq), 10000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
